bcd_display_ctrl: RTL and testbench

Sequential binary-to-BCD conversion controller that drives a 4-digit seven-segment bank (HEX3..HEX0) on the board.
Accepts a binary value through a LOAD/READY handshake and converts it with a shift-and-add-3 (double-dabble) FSM, one bit per cycle.
Holds the result in per-digit registers and feeds four instances of the team's Seven_seg_display decoder (active-low segments, bit order [0:6]).
Lets any datapath show a decimal result without a combinational divider.

---
 rtl/bcd_display_pkg.sv | 13 +
 rtl/Seven_seg_display.sv | 25 ++
 rtl/bcd_add3_nibble.sv | 14 +
 rtl/bcd_display_ctrl.sv | 140 ++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD seven-segment display controller.
package bcd_display_pkg;

   typedef enum logic {IDLE, CONV} state_e;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned BCD_W      = 16;
   localparam int unsigned SHIFT_W    = 14;

   localparam logic [0:6] SEG_BLANK = 7'b1111111;
   localparam logic [0:6] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/Seven_seg_display.sv
// BCD digit to active-low seven-segment pattern, segments ordered [0:6].
module Seven_seg_display
   import bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [0:6] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_ZERO;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction step: add 3 to a BCD nibble that is 5 or more.
module bcd_add3_nibble (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter driving four seven-segment digits.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (HEX0 always shown).
module bcd_display_ctrl
   import bcd_display_pkg::*;
#(
   parameter int unsigned WIDTH     = 14,
   parameter int unsigned MAX_VALUE = 9999
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] BIN_IN,
   input  logic             LOAD,
   output logic             READY,
   output logic             DONE,
   output logic             OVERFLOW,
   output logic [0:6]       HEX0,
   output logic [0:6]       HEX1,
   output logic [0:6]       HEX2,
   output logic [0:6]       HEX3
);

   state_e               state_q, state_d;
   logic [SHIFT_W-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]     scratch_q, scratch_d;
   logic [BCD_W-1:0]     digits_q, digits_d;
   logic [BCD_W-1:0]     corrected;
   logic [3:0]           cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 ovf_q, ovf_d;
   logic                 accept, last_bit, over;
   logic [SHIFT_W-1:0]   clamped;
   logic                 unused_msb;
   logic [0:6]           seg [NUM_DIGITS];

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (LOAD) state_d = CONV;
         CONV:    if (last_bit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      READY = (state_q == IDLE);
   end

   assign accept   = READY & LOAD;
   assign last_bit = (state_q == CONV) && (cnt_q == 4'(WIDTH - 1));
   assign over     = 32'(BIN_IN) > MAX_VALUE;
   assign clamped  = over ? SHIFT_W'(MAX_VALUE) : SHIFT_W'(BIN_IN);

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
      bcd_add3_nibble u_add3 (
         .din  (scratch_q[4*i +: 4]),
         .dout (corrected[4*i +: 4])
      );
   end

   // The top correction bit is shifted out; results never exceed 9999.
   assign unused_msb = corrected[BCD_W-1];

   always_comb begin
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      digits_d  = digits_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      if (accept) begin
         // Left-align so the MSB of a narrow input is shifted out first.
         shift_d   = clamped << (SHIFT_W - WIDTH);
         scratch_d = '0;
         cnt_d     = '0;
         ovf_d     = over;
      end else if (state_q == CONV) begin
         scratch_d = {corrected[BCD_W-2:0], shift_q[SHIFT_W-1]};
         shift_d   = {shift_q[SHIFT_W-2:0], 1'b0};
         cnt_d     = cnt_q + 4'd1;
         if (last_bit) begin
            digits_d = {corrected[BCD_W-2:0], shift_q[SHIFT_W-1]};
            done_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         digits_q  <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         digits_q  <= digits_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign DONE     = done_q;
   assign OVERFLOW = ovf_q;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
      Seven_seg_display u_seg (
         .bcd (digits_q[4*i +: 4]),
         .seg (seg[i])
      );
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      HEX0 = seg[0];
      HEX1 = (digits_q[15:4]  == '0) ? SEG_BLANK : seg[1];
      HEX2 = (digits_q[15:8]  == '0) ? SEG_BLANK : seg[2];
      HEX3 = (digits_q[15:12] == '0) ? SEG_BLANK : seg[3];
   end
`else
   assign HEX0 = seg[0];
   assign HEX1 = seg[1];
   assign HEX2 = seg[2];
   assign HEX3 = seg[3];
`endif

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed self-checking bench for bcd_display_ctrl with hand-computed segment patterns.
module tb_bcd_display_ctrl;

   logic        clk;
   logic        rst;
   logic [13:0] bin_in;
   logic        load;
   logic        ready, done, overflow;
   logic [0:6]  hex0, hex1, hex2, hex3;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = S0;
`endif

   bcd_display_ctrl dut (
      .Clock    (clk),
      .Reset    (rst),
      .BIN_IN   (bin_in),
      .LOAD     (load),
      .READY    (ready),
      .DONE     (done),
      .OVERFLOW (overflow),
      .HEX0     (hex0),
      .HEX1     (hex1),
      .HEX2     (hex2),
      .HEX3     (hex3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
      check({tag, "_hex3"}, 32'(hex3), 32'(e3));
      check({tag, "_hex2"}, 32'(hex2), 32'(e2));
      check({tag, "_hex1"}, 32'(hex1), 32'(e1));
      check({tag, "_hex0"}, 32'(hex0), 32'(e0));
   endtask

   // Advance past one rising edge and settle.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic done_seen;
      rst    = 1'b1;
      load   = 1'b0;
      bin_in = '0;
      tick(2);
      rst = 1'b0;

      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check_hex("rst", LZ, LZ, LZ, S0);

      // 1234: READY drops at E0, digits update and DONE pulses at E14
      bin_in = 14'd1234;
      load   = 1'b1;
      tick(1);
      load = 1'b0;
      check("t1_ready_low", 32'(ready), 32'd0);
      tick(13);
      check("t1_hold_e13", 32'(hex0), 32'(S0));
      check("t1_done_e13", 32'(done), 32'd0);
      tick(1);
      check_hex("t1", S1, S2, S3, S4);
      check("t1_done", 32'(done), 32'd1);
      check("t1_ready", 32'(ready), 32'd1);
      check("t1_ovf", 32'(overflow), 32'd0);
      tick(1);
      check("t1_done_once", 32'(done), 32'd0);

      // 9999 then 0 with LOAD held high
      bin_in = 14'd9999;
      load   = 1'b1;
      tick(1);
      bin_in = 14'd0;
      tick(14);
      check_hex("t2a", S9, S9, S9, S9);
      check("t2a_done", 32'(done), 32'd1);
      check("t2a_ready", 32'(ready), 32'd1);
      tick(1);
      load = 1'b0;
      check("t2b_accept", 32'(ready), 32'd0);
      tick(14);
      check_hex("t2b", LZ, LZ, LZ, S0);
      check("t2b_done", 32'(done), 32'd1);
      tick(1);

      // Clamp and sticky overflow
      bin_in = 14'd12000;
      load   = 1'b1;
      tick(1);
      load = 1'b0;
      check("t3_ovf_set", 32'(overflow), 32'd1);
      tick(14);
      check_hex("t3a", S9, S9, S9, S9);
      check("t3a_ovf", 32'(overflow), 32'd1);
      tick(1);
      check("t3_ovf_sticky", 32'(overflow), 32'd1);
      bin_in = 14'd5;
      load   = 1'b1;
      tick(1);
      load = 1'b0;
      check("t3_ovf_clr", 32'(overflow), 32'd0);
      tick(14);
      check_hex("t3b", LZ, LZ, LZ, S5);
      tick(1);

      // LOAD mid-conversion is ignored
      bin_in = 14'd42;
      load   = 1'b1;
      tick(1);
      load = 1'b0;
      tick(4);
      bin_in = 14'd77;
      load   = 1'b1;
      tick(1);
      load = 1'b0;
      check("t4_ready_e5", 32'(ready), 32'd0);
      tick(8);
      check("t4_ready_e13", 32'(ready), 32'd0);
      tick(1);
      check_hex("t4", LZ, LZ, S4, S2);
      check("t4_done", 32'(done), 32'd1);
      tick(1);

      // Reset mid-conversion aborts cleanly
      bin_in = 14'd8888;
      load   = 1'b1;
      tick(1);
      load = 1'b0;
      tick(6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t5_ready", 32'(ready), 32'd1);
      check("t5_done", 32'(done), 32'd0);
      check_hex("t5_rst", LZ, LZ, LZ, S0);
      done_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         done_seen = done_seen | done;
      end
      check("t5_no_done", 32'(done_seen), 32'd0);
      check_hex("t5_idle", LZ, LZ, LZ, S0);
      bin_in = 14'd8;
      load   = 1'b1;
      tick(1);
      load = 1'b0;
      tick(14);
      check_hex("t5_eight", LZ, LZ, LZ, S8);
      tick(1);

      // Reset wins over LOAD in the same cycle
      bin_in = 14'd3;
      load   = 1'b1;
      rst    = 1'b1;
      tick(1);
      rst  = 1'b0;
      load = 1'b0;
      check("t6_ready", 32'(ready), 32'd1);
      check("t6_hex0", 32'(hex0), 32'(S0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
